// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction prefetch stage.
// Provides fetch_entry_t ({pc, inst}), the default queue depth and the reset PC.
package fetch_pkg;
  localparam int FETCH_AW = 16;
  localparam int FETCH_DW = 16;
  localparam int FETCH_DEPTH_DEFAULT = 4;
  localparam logic [FETCH_AW-1:0] RESET_PC = '0;
  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with flush and occupancy count.
// Ports: clk_i, rst_ni (async active-low), flush_i (clears pointers/count, wins over push/pop),
// push_i/data_i (write), pop_i (read), head_o (entry at read pointer), count_o (entries held).
// The caller must not push when full without popping, nor pop when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] count_q, count_d;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d = flush_i ? '0 : wr_q + PW'(push_i);
    rd_d = flush_i ? '0 : rd_q + PW'(pop_i);
    count_d = flush_i ? '0 : count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end
  end
  assign head_o = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction prefetch queue between instruction memory and controller.
// Ports: clk, rst (async active-low); mem_addr/mem_rd/mem_data (memory read port, data combinational);
// inst_valid/inst/inst_pc/inst_ready (head handshake); redirect/redirect_pc (flush and restart);
// occupancy (entries held). Optional macro FETCH_BYPASS_EN: serve the head straight from memory
// when the queue is empty.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT,
  parameter int AW = FETCH_AW,
  parameter int DW = FETCH_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [AW-1:0]          mem_addr,
  output logic                   mem_rd,
  input  logic [DW-1:0]          mem_data,
  output logic                   inst_valid,
  output logic [DW-1:0]          inst,
  output logic [AW-1:0]          inst_pc,
  input  logic                   inst_ready,
  input  logic                   redirect,
  input  logic [AW-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count;
  fetch_entry_t head;
  logic deq, enq, push, pop, byp;
  always_comb begin
`ifdef FETCH_BYPASS_EN
    byp = rst && !redirect && count == '0;
`else
    byp = 1'b0;
`endif
    inst_valid = count != '0 || byp;
    inst = byp ? mem_data : head.inst;
    inst_pc = byp ? fetch_pc_q : head.pc;
    deq = inst_valid && inst_ready;
    // rst gating keeps the read port idle while reset is held.
    enq = rst && !redirect && (count < CW'(DEPTH) || deq);
    // A bypassed word that is consumed at once never touches storage.
    push = enq && !(byp && inst_ready);
    pop = deq && !byp;
    mem_rd = enq;
    mem_addr = fetch_pc_q;
    occupancy = count;
    fetch_pc_d = redirect ? redirect_pc : fetch_pc_q + AW'(enq);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_pc_q <= RESET_PC;
    else fetch_pc_q <= fetch_pc_d;
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .flush_i(redirect),
    .push_i (push),
    .data_i ('{pc: fetch_pc_q, inst: mem_data}),
    .pop_i  (pop),
    .head_o (head),
    .count_o(count)
  );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed table-driven checks of the prefetch queue plus an async-reset sequence.
module tb_inst_fetch_queue;
  logic clk = 1'b0;
  logic rst, mem_rd, inst_valid, inst_ready, redirect;
  logic [15:0] mem_addr, mem_data, inst, inst_pc, redirect_pc, exp_inst;
  logic [2:0] occupancy;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic rst, rdy, redir;
    logic [15:0] rpc;
    logic v;
    logic [15:0] pc;
    logic [2:0] occ;
    logic rd;
    logic [15:0] addr;
  } vec_t;
  vec_t tv[$];
  inst_fetch_queue dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .occupancy(occupancy)
  );
  assign mem_data = 16'h1000 + mem_addr;
  initial forever #5 clk = ~clk;
  function automatic vec_t mk(int r, int rdy, int rdr, int rpc, int v, int pc, int occ, int rd, int addr);
    vec_t t;
    t.rst = r[0]; t.rdy = rdy[0]; t.redir = rdr[0]; t.rpc = rpc[15:0];
    t.v = v[0]; t.pc = pc[15:0]; t.occ = occ[2:0]; t.rd = rd[0]; t.addr = addr[15:0];
    return t;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  initial begin
    tv.push_back(mk(0,0,0,0, 0,0,0,0,0));
    tv.push_back(mk(1,1,0,0, 0,0,0,1,0));
    tv.push_back(mk(1,1,0,0, 1,0,1,1,1));
    tv.push_back(mk(1,1,0,0, 1,1,1,1,2));
    tv.push_back(mk(1,1,0,0, 1,2,1,1,3));
    tv.push_back(mk(0,0,0,0, 0,0,0,0,0));
    tv.push_back(mk(1,0,0,0, 0,0,0,1,0));
    tv.push_back(mk(1,0,0,0, 1,0,1,1,1));
    tv.push_back(mk(1,0,0,0, 1,0,2,1,2));
    tv.push_back(mk(1,0,0,0, 1,0,3,1,3));
    tv.push_back(mk(1,0,0,0, 1,0,4,0,4));
    tv.push_back(mk(1,0,0,0, 1,0,4,0,4));
    for (int i = 0; i < 10; i++) tv.push_back(mk(1,1,0,0, 1,i,4,1,4+i));
    tv.push_back(mk(1,0,1,'h40, 1,'hA,4,0,'hE));
    tv.push_back(mk(1,0,0,0, 0,0,0,1,'h40));
    tv.push_back(mk(1,0,0,0, 1,'h40,1,1,'h41));
    tv.push_back(mk(1,0,0,0, 1,'h40,2,1,'h42));
    tv.push_back(mk(1,0,1,'h20, 1,'h40,3,0,'h43));
    tv.push_back(mk(1,0,0,0, 0,0,0,1,'h20));
    tv.push_back(mk(1,0,0,0, 1,'h20,1,1,'h21));
    tv.push_back(mk(1,1,1,'hFFFE, 1,'h20,2,0,'h22));
    tv.push_back(mk(1,1,0,0, 0,0,0,1,'hFFFE));
    tv.push_back(mk(1,1,0,0, 1,'hFFFE,1,1,'hFFFF));
    tv.push_back(mk(1,1,0,0, 1,'hFFFF,1,1,0));
    tv.push_back(mk(1,1,0,0, 1,0,1,1,1));
    tv.push_back(mk(1,1,0,0, 1,1,1,1,2));
    rst = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1 rst = 1'b0;
    #1;
    chk("reset inst", inst, 16'h0);
    chk("reset inst_pc", inst_pc, 16'h0);
    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].rst; inst_ready = tv[i].rdy; redirect = tv[i].redir; redirect_pc = tv[i].rpc;
      #1;
      chk($sformatf("row%0d inst_valid", i), inst_valid, tv[i].v);
      chk($sformatf("row%0d occupancy", i), occupancy, tv[i].occ);
      chk($sformatf("row%0d mem_rd", i), mem_rd, tv[i].rd);
      chk($sformatf("row%0d mem_addr", i), mem_addr, tv[i].addr);
      if (tv[i].v) begin
        exp_inst = 16'h1000 + tv[i].pc;
        chk($sformatf("row%0d inst_pc", i), inst_pc, tv[i].pc);
        chk($sformatf("row%0d inst", i), inst, exp_inst);
      end
    end
    redirect = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async rst inst_valid", inst_valid, 1'b0);
    chk("async rst inst", inst, 16'h0);
    chk("async rst inst_pc", inst_pc, 16'h0);
    chk("async rst occupancy", occupancy, 3'd0);
    chk("async rst mem_rd", mem_rd, 1'b0);
    chk("async rst mem_addr", mem_addr, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release mem_rd", mem_rd, 1'b1);
    chk("release mem_addr", mem_addr, 16'h0);
    chk("release inst_valid", inst_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("restart inst_valid", inst_valid, 1'b1);
    chk("restart inst_pc", inst_pc, 16'h0);
    chk("restart inst", inst, 16'h1000);
    chk("restart mem_addr", mem_addr, 16'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
